// File: rtl/frame_buf_ctrl.sv
// Triple-buffer scheduler: hands the camera writer a free buffer each frame and
// gives the display reader the newest completed buffer at each vsync.
module frame_buf_ctrl #(
    parameter logic [31:0] BUF_BASE       = 32'h1000_0000,
    parameter logic [31:0] BUF_STRIDE     = 32'h0004_0000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd3_000_000
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        writer_done,
    input  logic        rd_frame_start,
    output logic [31:0] wr_base_addr,
    output logic        buf_select,
    output logic [31:0] rd_base_addr,
    output logic [1:0]  wr_idx,
    output logic [1:0]  rd_idx,
    output logic [1:0]  state,
    output logic [15:0] frame_cnt,
    output logic [15:0] skip_cnt,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_WRITE  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_fs_d1;
    logic        r_wd_d1;
    logic [1:0]  r_wr_idx;
    logic [1:0]  r_rd_idx;
    logic [1:0]  r_last_idx;
    logic        r_new_frame;
    logic        r_buf_select;
    logic [31:0] r_wr_base;
    logic [31:0] r_rd_base;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_skip_cnt;
    logic        r_timeout_err;
    logic [23:0] r_wdog;

    logic        w_fs_rise;
    logic        w_wd_rise;
    logic        w_rd_take;
    logic [1:0]  w_rd_next;
    logic [1:0]  w_wr_next;

    function automatic logic [31:0] f_base(input logic [1:0] idx);
        return BUF_BASE + BUF_STRIDE * {30'd0, idx};
    endfunction

    assign w_fs_rise = frame_start & ~r_fs_d1;
    assign w_wd_rise = writer_done & ~r_wd_d1;
    assign w_rd_take = rd_frame_start & r_new_frame;
    // The three indices always sum to 3, so the free buffer is whatever the
    // reader and the just-committed frame are not using.
    assign w_rd_next = w_rd_take ? r_last_idx : r_rd_idx;
    assign w_wr_next = 2'd3 - r_wr_idx - w_rd_next;

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fs_d1       <= 1'b0;
            r_wd_d1       <= 1'b0;
            r_wr_idx      <= 2'd1;
            r_rd_idx      <= 2'd0;
            r_last_idx    <= 2'd2;
            r_new_frame   <= 1'b0;
            r_buf_select  <= 1'b0;
            r_wr_base     <= f_base(2'd1);
            r_rd_base     <= f_base(2'd0);
            r_frame_cnt   <= 16'd0;
            r_skip_cnt    <= 16'd0;
            r_timeout_err <= 1'b0;
            r_wdog        <= 24'd0;
        end else begin
            r_fs_d1 <= frame_start;
            r_wd_d1 <= writer_done;

            if (w_rd_take) begin
                r_rd_idx    <= r_last_idx;
                r_rd_base   <= f_base(r_last_idx);
                r_new_frame <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) r_state <= S_ARM;
                end
                S_ARM: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_fs_rise) begin
                        r_state      <= S_WRITE;
                        r_buf_select <= ~r_buf_select;
                        r_wdog       <= 24'd0;
                    end
                end
                S_WRITE: begin
                    r_wdog <= r_wdog + 24'd1;
                    if (w_wd_rise) begin
                        r_state <= S_COMMIT;
                    end else if (r_wdog == TIMEOUT_CYCLES - 24'd1) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ARM;
                    end
                end
                S_COMMIT: begin
                    r_last_idx  <= r_wr_idx;
                    r_wr_idx    <= w_wr_next;
                    r_wr_base   <= f_base(w_wr_next);
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    // A pending frame consumed by this cycle's vsync was shown, not skipped.
                    if (r_new_frame && !w_rd_take) r_skip_cnt <= r_skip_cnt + 16'd1;
                    r_new_frame <= 1'b1;
                    r_state     <= S_ARM;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_base_addr = r_wr_base;
    assign buf_select   = r_buf_select;
    assign rd_base_addr = r_rd_base;
    assign wr_idx       = r_wr_idx;
    assign rd_idx       = r_rd_idx;
    assign state        = r_state;
    assign frame_cnt    = r_frame_cnt;
    assign skip_cnt     = r_skip_cnt;
    assign timeout_err  = r_timeout_err;

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
- Triple-buffer scheduler for the camera-to-DDR write path and the DDR-to-HDMI read path, in the 100 MHz AXI domain.
- Hands the AXI stream-to-memory writer its frame base address and buf_select toggle at each camera frame start, and commits completed frames on writer_done.
- Gives the display reader the newest completed buffer at each display frame start. The reader never sees a buffer the writer is filling.

Parameters:
BUF_BASE, 32'h1000_0000, DDR byte address of buffer 0
BUF_STRIDE, 32'h0004_0000, byte distance between buffers (>= 153600 for one 320x240x16b frame)
TIMEOUT_CYCLES, 24'd3_000_000, maximum WRITE duration before abort (30 ms)

Ports:
clk_100Mhz  in  1  sole clock
rst  in  1  synchronous, active-high reset
enable  in  1  level; 1 = run scheduling
frame_start  in  1  camera frame-start level, already synchronised; rising edge detected internally
writer_done  in  1  writer frame-complete level; rising edge detected internally
rd_frame_start  in  1  single-cycle pulse from display reader at display vsync
wr_base_addr  out  32  base address for the writer (drives its FRAME_BASE_ADDR)
buf_select  out  1  toggles once per accepted camera frame
rd_base_addr  out  32  base address for the display reader
wr_idx  out  2  buffer being written
rd_idx  out  2  buffer being displayed
state  out  2  0 IDLE, 1 ARM, 2 WRITE, 3 COMMIT
frame_cnt  out  16  committed frames, wraps at 65535->0
skip_cnt  out  16  committed frames overwritten before display, wraps
timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset values:
  - state=IDLE, wr_idx=1, rd_idx=0, last_idx=2 (internal), new_frame=0 (internal).
  - buf_select=0, frame_cnt=0, skip_cnt=0, timeout_err=0, watchdog=0.
  - wr_base_addr=BUF_BASE+BUF_STRIDE, rd_base_addr=BUF_BASE.
  - Edge-detect delay flops = 0.
- Address rule: any base = BUF_BASE + idx*BUF_STRIDE, 32-bit, overflow ignored. Each base is registered and updates on the same edge as its idx.
- Edge detect: rise = in & ~in_d1, with in_d1 a one-cycle delayed copy.
- IDLE: enable=1 -> ARM.
- ARM:
  - enable=0 -> IDLE.
  - frame_start rise -> WRITE. Toggle buf_select and clear the watchdog on that edge.
- WRITE:
  - Watchdog increments every cycle.
  - writer_done rise -> COMMIT.
  - Otherwise, watchdog == TIMEOUT_CYCLES-1 -> set timeout_err and go to ARM. The frame is dropped: no commit, wr_idx unchanged.
  - enable=0 is ignored here; it is acted on in ARM.
- COMMIT (exactly one cycle):
  - last_idx <= wr_idx.
  - wr_idx <= 3 - wr_idx - rd_next, where rd_next is the rd_idx value being written this cycle.
  - frame_cnt++.
  - If new_frame was already 1, skip_cnt++.
  - new_frame <= 1, then -> ARM.
- Reader update runs in any state:
  - rd_frame_start && new_frame: rd_idx <= last_idx (pre-commit value) and new_frame <= 0.
  - rd_frame_start && !new_frame: no change.
- Simultaneous rd_frame_start and COMMIT:
  - The reader takes the old last_idx.
  - new_frame ends at 1, so the fresh frame is shown at the next vsync.
  - skip_cnt counts only if new_frame was 1 before that cycle's read, i.e. a stale pending frame is overwritten.
- Invariant: wr_idx, rd_idx and last_idx are pairwise distinct at all times. Bench asserts every cycle.
- Latency: writer_done rising at edge n -> COMMIT at n+1 -> new wr_idx/wr_base_addr visible at n+2.
- wr_base_addr is stable throughout WRITE.
- A frame_start rise while in WRITE or COMMIT is ignored (no toggle).
- rst mid-frame restores all reset values on the next edge regardless of state.

Test Plan:
- Reset then enable=1, frame_start rise -> buf_select 0->1, state=WRITE, wr_base_addr=32'h1004_0000.
- writer_done rise at edge n -> COMMIT at n+1. At n+2: wr_idx=2, wr_base_addr=32'h1008_0000, frame_cnt=1, state=ARM.
- rd_frame_start after that commit -> rd_idx=1, rd_base_addr=32'h1004_0000. A second rd_frame_start with no new commit -> rd_idx stays 1.
- Two commits with no rd_frame_start -> skip_cnt=1, frame_cnt=2. Next vsync gives rd_idx = the last committed index; invariant holds throughout.
- rd_frame_start on the same cycle as COMMIT -> reader gets the previous frame, new_frame=1 afterwards, skip_cnt unchanged.
- TIMEOUT_CYCLES=100, no writer_done -> timeout_err=1 after 100 WRITE cycles, state=ARM, wr_idx unchanged, frame_cnt unchanged. rst -> timeout_err=0 and all reset values restored.
